// File: rtl/uart_pkg.sv
// Shared types and defaults for the serial command receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    localparam int BAUD_DIV_DFLT     = 2604;
    localparam int TIMEOUT_BITS_DFLT = 20;

endpackage

// File: rtl/uart_cmd_rcv_if.sv
// Command handshake bundle between the receiver (master) and the
// MazeRunner command processor (slave).
interface uart_cmd_rcv_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frm_err;
    logic        ovr;

    modport master (output cmd, cmd_rdy, frm_err, ovr, input clr_cmd_rdy);
    modport slave  (input cmd, cmd_rdy, frm_err, ovr, output clr_cmd_rdy);

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: RX synchronizer, start-edge detect, bit FSM and
// baud counter. rx_vld / rx_ferr are high during the stop-sample cycle.
// Optional build macro: UART_CMD_TIMEOUT_EN (adds the rx_busy output).
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
`ifdef UART_CMD_TIMEOUT_EN
    output logic       rx_busy,
`endif
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr
);

    localparam int CW = $clog2(BAUD_DIV);
    // The counter expires on 0, so a load of N-1 gives an N-clock period.
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic            fall;
    logic            expire;
    rx_state_t       state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    // Two-flop synchronizer plus one edge-detect stage, all idling high.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall   = rx_prev & ~rx_sync;
    assign expire = (baud_cnt == '0);

    // Bit FSM: half-bit wait to the start-bit centre, then one sample per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_cnt <= HALF_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (!expire) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (rx_sync) begin
                        state <= IDLE;          // glitch, not a start bit
                    end else begin
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        shift    <= {rx_sync, shift[7:1]};
                        baud_cnt <= FULL_LOAD;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (!expire) baud_cnt <= baud_cnt - 1'b1;
                    else         state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_data = shift;
    assign rx_vld  = (state == STOP) && expire &&  rx_sync;
    assign rx_ferr = (state == STOP) && expire && !rx_sync;
`ifdef UART_CMD_TIMEOUT_EN
    assign rx_busy = (state != IDLE);
`endif

endmodule

// File: rtl/uart_cmd_rcv.sv
// Serial command receiver: pairs bytes (high first) into a 16-bit command
// with a sticky cmd_rdy / clr_cmd_rdy handshake, frm_err and ovr pulses.
// Optional build macro: UART_CMD_TIMEOUT_EN (WAIT_LO timeout).
module uart_cmd_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV     = BAUD_DIV_DFLT,
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RX,
    uart_cmd_rcv_if.master  bus
);

    if (BAUD_DIV < 16 || TIMEOUT_BITS < 1) begin : g_param_chk
        $error("uart_cmd_rcv: BAUD_DIV must be >= 16 and TIMEOUT_BITS >= 1");
    end

    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_ferr;
    logic       done;
    logic       tmo_hit;
    asm_state_t asm_state;
    logic [7:0] hi_byte;

`ifdef UART_CMD_TIMEOUT_EN
    logic rx_busy;
`endif

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_byte_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
`ifdef UART_CMD_TIMEOUT_EN
        .rx_busy (rx_busy),
`endif
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_ferr (rx_ferr)
    );

    assign done = rx_vld && (asm_state == WAIT_LO);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW        = $clog2(TMO_LIMIT + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (asm_state == WAIT_LO) && !rx_busy &&
                     (tmo_cnt == TW'(TMO_LIMIT - 1));

    // Idle time in WAIT_LO; frozen while a frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      tmo_cnt <= '0;
        else if (asm_state != WAIT_LO)   tmo_cnt <= '0;
        else if (!rx_busy && !tmo_hit)   tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Byte assembler: a framing error or timeout drops any pending high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
            hi_byte   <= '0;
        end else if (rx_ferr || tmo_hit) begin
            asm_state <= WAIT_HI;
        end else if (rx_vld) begin
            if (asm_state == WAIT_HI) begin
                hi_byte   <= rx_data;
                asm_state <= WAIT_LO;
            end else begin
                asm_state <= WAIT_HI;
            end
        end
    end

    // Handshake and status pulses; a completing command beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cmd     <= '0;
            bus.cmd_rdy <= 1'b0;
            bus.frm_err <= 1'b0;
            bus.ovr     <= 1'b0;
        end else begin
            bus.frm_err <= rx_ferr;
            bus.ovr     <= done && bus.cmd_rdy && !bus.clr_cmd_rdy;
            if (done) begin
                bus.cmd     <= {hi_byte, rx_data};
                bus.cmd_rdy <= 1'b1;
            end else if (bus.clr_cmd_rdy) begin
                bus.cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv with a byte-level model of the command
// link and a per-cycle compare of the handshake outputs.
// Optional build macro: UART_CMD_TIMEOUT_EN (enables the timeout scenario).
module tb_uart_cmd_rcv;

    localparam int B       = 32;
    localparam int H       = B / 2;
    localparam int TO_BITS = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_cmd_rcv_if bus ();

    uart_cmd_rcv #(.BAUD_DIV(B), .TIMEOUT_BITS(TO_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the link seen at byte level
    logic [15:0] exp_cmd   = '0;
    logic        exp_rdy   = 1'b0;
    logic        hi_pend   = 1'b0;
    logic [7:0]  hi_val    = '0;
    int          exp_ferr  = 0;
    int          exp_ovr   = 0;
    int          ferr_seen = 0;
    int          ovr_seen  = 0;
    logic        prev_ferr = 1'b0;
    logic        prev_ovr  = 1'b0;
    logic        settle    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Byte-level rules: a good stop bit delivers a byte, bad stop drops the pair
    task automatic model_byte(input logic [7:0] b, input logic stop, input logic clr_done);
        if (!stop) begin
            exp_ferr++;
            hi_pend = 1'b0;
        end else if (!hi_pend) begin
            hi_pend = 1'b1;
            hi_val  = b;
        end else begin
            if (exp_rdy && !clr_done) exp_ovr++;
            exp_cmd = {hi_val, b};
            exp_rdy = 1'b1;
            hi_pend = 1'b0;
        end
    endtask

    // mode 0: plain, 1: clr_cmd_rdy on the completion cycle, 2: latency probe
    task automatic send_byte(input logic [7:0] b, input logic stop, input int mode);
        settle = 1'b1;
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(B);
        end
        rx = stop;
        if (mode == 1) begin
            tick(H + 2);
            bus.clr_cmd_rdy = 1'b1;
            tick(1);
            bus.clr_cmd_rdy = 1'b0;
            tick(B - H - 3);
        end else if (mode == 2) begin
            tick(H + 2);
            check("lat_rdy_before", bus.cmd_rdy, 1'b0);
            tick(1);
            check("lat_rdy_after", bus.cmd_rdy, 1'b1);
            tick(B - H - 3);
        end else begin
            tick(B);
        end
        rx = 1'b1;
        model_byte(b, stop, mode == 1);
        check("ferr_count", ferr_seen, exp_ferr);
        check("ovr_count", ovr_seen, exp_ovr);
        settle = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] w, input int mode);
        send_byte(w[15:8], 1'b1, 0);
        send_byte(w[7:0], 1'b1, mode);
    endtask

    task automatic clear_rdy();
        settle = 1'b1;
        bus.clr_cmd_rdy = 1'b1;
        tick(1);
        bus.clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        settle = 1'b0;
    endtask

    // Per-cycle compare against the model, plus pulse accounting
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frm_err) begin
                ferr_seen++;
                check("frm_err_width", prev_ferr, 1'b0);
            end
            if (bus.ovr) begin
                ovr_seen++;
                check("ovr_width", prev_ovr, 1'b0);
            end
            prev_ferr = bus.frm_err;
            prev_ovr  = bus.ovr;
            if (!settle) begin
                check("cmd", bus.cmd, exp_cmd);
                check("cmd_rdy", bus.cmd_rdy, exp_rdy);
                check("frm_err_quiet", bus.frm_err, 1'b0);
                check("ovr_quiet", bus.ovr, 1'b0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int o0;
        bus.clr_cmd_rdy = 1'b0;
        tick(5);
        check("rst_cmd", bus.cmd, 16'h0000);
        check("rst_rdy", bus.cmd_rdy, 1'b0);
        check("rst_ferr", bus.frm_err, 1'b0);
        check("rst_ovr", bus.ovr, 1'b0);
        rst_n = 1'b1;
        tick(2);
        settle = 1'b0;
        tick(B);

        // Single command, exact cmd_rdy latency, then clear
        send_cmd(16'h0001, 2);
        check("t1_cmd", bus.cmd, 16'h0001);
        check("t1_rdy", bus.cmd_rdy, 1'b1);
        clear_rdy();
        tick(2);
        check("t1_rdy_clr", bus.cmd_rdy, 1'b0);
        check("t1_cmd_kept", bus.cmd, 16'h0001);

        // Overrun, then set-wins on a simultaneous clear
        o0 = ovr_seen;
        send_cmd(16'h0002, 0);
        send_cmd(16'hA5C3, 0);
        check("t2_ovr_once", ovr_seen - o0, 1);
        check("t2_cmd", bus.cmd, 16'hA5C3);
        send_cmd(16'h5A3C, 1);
        check("t2_setwins_rdy", bus.cmd_rdy, 1'b1);
        check("t2_setwins_noovr", ovr_seen - o0, 1);
        check("t2_setwins_cmd", bus.cmd, 16'h5A3C);
        clear_rdy();

        // Framing error on a lone high byte, then on a low byte
        f0 = ferr_seen;
        send_byte(8'h12, 1'b0, 0);
        tick(B);
        check("t3_ferr_once", ferr_seen - f0, 1);
        check("t3_no_rdy", bus.cmd_rdy, 1'b0);
        send_cmd(16'h0102, 0);
        check("t3_cmd", bus.cmd, 16'h0102);
        clear_rdy();
        send_byte(8'h77, 1'b1, 0);
        send_byte(8'h55, 1'b0, 0);
        tick(B);
        send_cmd(16'h0304, 0);
        check("t3_resync_cmd", bus.cmd, 16'h0304);
        check("t3_ferr_twice", ferr_seen - f0, 2);
        clear_rdy();

        // Glitch shorter than half a bit
        settle = 1'b1;
        rx = 1'b0;
        tick(B / 4);
        rx = 1'b1;
        tick(2 * B);
        settle = 1'b0;
        tick(1);
        check("t4_glitch_rdy", bus.cmd_rdy, 1'b0);
        send_cmd(16'h00FF, 0);
        check("t4_cmd", bus.cmd, 16'h00FF);

        // Reset in the middle of a frame with a high byte pending
        send_byte(8'h99, 1'b1, 0);
        settle = 1'b1;
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h12 >> i) & 1'b1;
            tick(B);
        end
        rst_n = 1'b0;
        tick(3);
        exp_cmd = '0;
        exp_rdy = 1'b0;
        hi_pend = 1'b0;
        check("t5_rst_cmd", bus.cmd, 16'h0000);
        check("t5_rst_rdy", bus.cmd_rdy, 1'b0);
        rx = 1'b1;
        rst_n = 1'b1;
        tick(2 * B);
        settle = 1'b0;
        send_cmd(16'h1234, 0);
        check("t5_cmd", bus.cmd, 16'h1234);
        clear_rdy();

`ifdef UART_CMD_TIMEOUT_EN
        // Lost low byte recovered by the WAIT_LO timeout
        send_byte(8'hAB, 1'b1, 0);
        tick(25 * B);
        if (25 > TO_BITS) hi_pend = 1'b0;
        send_cmd(16'h0003, 0);
        check("t6_cmd", bus.cmd, 16'h0003);
        clear_rdy();
`endif

        tick(B);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
